// File: rtl/qea_seq_pkg.sv
// qea_seq_pkg: shared parameters, FSM state encoding and depth helper for the QEA job sequencer.
package qea_seq_pkg;
    localparam int PE_NUM_WIDTH = 2;
    localparam int PE_NUM = 4;
    localparam int DATA_WIDTH = 32;
    localparam int STATE_DATA_WIDTH = 2 * DATA_WIDTH;
    localparam int STATE_ADDR_WIDTH = 16;
    localparam int GATE_CONTEXT_DATA_WIDTH = 2 * DATA_WIDTH;
    localparam int GATE_CONTEXT_ADDR_WIDTH = 16;
    localparam int MAX_QBIT_WIDTH = 6;
    localparam int NUM_FRAC_BIT = 30;
    localparam int RD_LAT = 1;
    localparam int CYC_WIDTH = 32;
    localparam int WORD_WIDTH = PE_NUM * STATE_DATA_WIDTH;
    localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1) << NUM_FRAC_BIT;

    typedef enum logic [3:0] {
        IDLE, LOAD_CTX, INIT_ST, START, RUN, READ_ISSUE, READ_WAIT, READ_HOLD, DONE
    } state_t;

    // Number of state RAM words; one extra bit so a full 2^STATE_ADDR_WIDTH fits.
    function automatic logic [STATE_ADDR_WIDTH:0] depth(input logic [MAX_QBIT_WIDTH-1:0] qbit);
        return (STATE_ADDR_WIDTH + 1)'(1) << (qbit - MAX_QBIT_WIDTH'(PE_NUM_WIDTH));
    endfunction
endpackage

// File: rtl/qea_job_sequencer_if.sv
// qea_job_sequencer_if: host command/context stream, QEA load/start/readout ports and result stream.
interface qea_job_sequencer_if;
    import qea_seq_pkg::*;
    logic i_cmd_start;
    logic [MAX_QBIT_WIDTH-1:0] i_qbit_num;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0] i_ins_num;
    logic i_ctx_valid;
    logic o_ctx_ready;
    logic [GATE_CONTEXT_DATA_WIDTH-1:0] i_ctx_word;
    logic o_qea_start;
    logic [MAX_QBIT_WIDTH-1:0] o_qea_qbit_num;
    logic o_qea_ctx_en;
    logic o_qea_ctx_wea;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0] o_qea_ctx_addr;
    logic [GATE_CONTEXT_DATA_WIDTH-1:0] o_qea_ctx_data;
    logic o_qea_state_ena;
    logic o_qea_state_wea;
    logic [STATE_ADDR_WIDTH-1:0] o_qea_state_addra;
    logic [WORD_WIDTH-1:0] o_qea_state_dina;
    logic i_qea_complete;
    logic [WORD_WIDTH-1:0] i_qea_state_dout;
    logic o_out_valid;
    logic i_out_ready;
    logic [WORD_WIDTH-1:0] o_out_data;
    logic o_out_last;
    logic o_busy;
    logic o_done;
    logic o_err;
    logic [CYC_WIDTH-1:0] o_exec_cycles;

    modport master (
        input  i_cmd_start, i_qbit_num, i_ins_num, i_ctx_valid, i_ctx_word,
               i_qea_complete, i_qea_state_dout, i_out_ready,
        output o_ctx_ready, o_qea_start, o_qea_qbit_num, o_qea_ctx_en, o_qea_ctx_wea,
               o_qea_ctx_addr, o_qea_ctx_data, o_qea_state_ena, o_qea_state_wea,
               o_qea_state_addra, o_qea_state_dina, o_out_valid, o_out_data, o_out_last,
               o_busy, o_done, o_err, o_exec_cycles
    );

    modport slave (
        output i_cmd_start, i_qbit_num, i_ins_num, i_ctx_valid, i_ctx_word,
               i_qea_complete, i_qea_state_dout, i_out_ready,
        input  o_ctx_ready, o_qea_start, o_qea_qbit_num, o_qea_ctx_en, o_qea_ctx_wea,
               o_qea_ctx_addr, o_qea_ctx_data, o_qea_state_ena, o_qea_state_wea,
               o_qea_state_addra, o_qea_state_dina, o_out_valid, o_out_data, o_out_last,
               o_busy, o_done, o_err, o_exec_cycles
    );
endinterface

// File: rtl/qea_seq_readout.sv
// qea_seq_readout: walks the state RAM, waits out the read latency and holds each word until accepted.
module qea_seq_readout
    import qea_seq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  state_t st,
    input  logic [STATE_ADDR_WIDTH:0] dep,
    input  logic [WORD_WIDTH-1:0] dout,
    input  logic out_ready,
    output logic rd_ena,
    output logic [STATE_ADDR_WIDTH-1:0] rd_addr,
    output logic lat_done,
    output logic last,
    output logic out_valid,
    output logic [WORD_WIDTH-1:0] out_data,
    output logic out_last
);
    localparam int LW = $clog2(RD_LAT + 1);
    logic [STATE_ADDR_WIDTH-1:0] addr;
    logic [LW-1:0] lat;

    assign rd_ena = st == READ_ISSUE;
    assign rd_addr = addr;
    assign lat_done = st == READ_WAIT && lat == LW'(RD_LAT - 1);
    assign last = (STATE_ADDR_WIDTH + 1)'(addr) == dep - 1'b1;
    assign out_valid = st == READ_HOLD;
    assign out_last = out_valid && last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
            lat <= '0;
            out_data <= '0;
        end else begin
            addr <= st == START ? '0 : (out_valid && out_ready) ? addr + 1'b1 : addr;
            lat <= st == READ_WAIT ? lat + 1'b1 : '0;
            if (lat_done)
                out_data <= dout;
        end
    end
endmodule

// File: rtl/qea_job_sequencer.sv
// qea_job_sequencer: loads context, initialises |0..0>, runs the QEA core, times it and streams the state out.
module qea_job_sequencer
    import qea_seq_pkg::*;
(
    input logic clk,
    input logic rst,
    qea_job_sequencer_if.master bus
);
    state_t st, nx;
    logic [MAX_QBIT_WIDTH-1:0] qbit;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ins, cnt, ctx_addr;
    logic [GATE_CONTEXT_DATA_WIDTH-1:0] ctx_data;
    logic [STATE_ADDR_WIDTH:0] dep;
    logic [STATE_ADDR_WIDTH-1:0] rd_addr;
    logic [CYC_WIDTH-1:0] exec;
    logic err, err_done, ctx_en, bad, hs, ctx_last, init, init_last, rd_ena, lat_done, rd_last;

    assign dep = depth(qbit);
    assign bad = bus.i_ins_num == '0 || bus.i_qbit_num < MAX_QBIT_WIDTH'(PE_NUM_WIDTH)
              || bus.i_qbit_num > MAX_QBIT_WIDTH'(PE_NUM_WIDTH + STATE_ADDR_WIDTH);
    assign hs = bus.i_ctx_valid && bus.o_ctx_ready;
    assign ctx_last = cnt == ins - 1'b1;
    assign init = st == INIT_ST;
    assign init_last = (STATE_ADDR_WIDTH + 1)'(cnt) == dep - 1'b1;

    always_comb begin
        nx = st;
        unique case (st)
            IDLE:       nx = (bus.i_cmd_start && !bad) ? LOAD_CTX : IDLE;
            LOAD_CTX:   nx = (hs && ctx_last) ? INIT_ST : LOAD_CTX;
            INIT_ST:    nx = init_last ? START : INIT_ST;
            START:      nx = RUN;
            RUN:        nx = bus.i_qea_complete ? READ_ISSUE : RUN;
            READ_ISSUE: nx = READ_WAIT;
            READ_WAIT:  nx = lat_done ? READ_HOLD : READ_WAIT;
            READ_HOLD:  nx = bus.i_out_ready ? (rd_last ? DONE : READ_ISSUE) : READ_HOLD;
            DONE:       nx = IDLE;
            default:    nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= IDLE;
            qbit <= '0;
            ins <= '0;
            cnt <= '0;
            err <= 1'b0;
            err_done <= 1'b0;
            ctx_en <= 1'b0;
            ctx_addr <= '0;
            ctx_data <= '0;
            exec <= '0;
        end else begin
            st <= nx;
            err_done <= st == IDLE && bus.i_cmd_start && bad;
            if (st == IDLE && bus.i_cmd_start) begin
                qbit <= bus.i_qbit_num;
                ins <= bus.i_ins_num;
                err <= bad;
            end
            ctx_en <= hs;
            if (hs) begin
                ctx_addr <= cnt;
                ctx_data <= bus.i_ctx_word;
            end
            // Shared counter: context index while loading, then state address while initialising.
            cnt <= (st == IDLE || (hs && ctx_last)) ? '0 : (hs || init) ? cnt + 1'b1 : cnt;
            if (st == START)
                exec <= '0;
            else if (st == RUN && !bus.i_qea_complete && exec != '1)
                exec <= exec + 1'b1;
        end
    end

    assign bus.o_ctx_ready = st == LOAD_CTX;
    assign bus.o_qea_ctx_en = ctx_en;
    assign bus.o_qea_ctx_wea = ctx_en;
    assign bus.o_qea_ctx_addr = ctx_addr;
    assign bus.o_qea_ctx_data = ctx_data;
    assign bus.o_qea_start = st == START;
    assign bus.o_qea_qbit_num = qbit;
    assign bus.o_qea_state_ena = init || rd_ena;
    assign bus.o_qea_state_wea = init;
    assign bus.o_qea_state_addra = init ? STATE_ADDR_WIDTH'(cnt) : rd_addr;
    assign bus.o_qea_state_dina = (init && cnt == '0) ? {ONE, (WORD_WIDTH - DATA_WIDTH)'(0)} : '0;
    assign bus.o_busy = st != IDLE;
    assign bus.o_done = st == DONE || err_done;
    assign bus.o_err = err;
    assign bus.o_exec_cycles = exec;

    qea_seq_readout u_readout (
        .clk(clk),
        .rst(rst),
        .st(st),
        .dep(dep),
        .dout(bus.i_qea_state_dout),
        .out_ready(bus.i_out_ready),
        .rd_ena(rd_ena),
        .rd_addr(rd_addr),
        .lat_done(lat_done),
        .last(rd_last),
        .out_valid(bus.o_out_valid),
        .out_data(bus.o_out_data),
        .out_last(bus.o_out_last)
    );
endmodule

// File: tb/tb_qea_job_sequencer.sv
// tb_qea_job_sequencer: randomized jobs against a reference of the job rules plus a latency-1 state RAM model.
module tb_qea_job_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    qea_job_sequencer_if bus();
    qea_job_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    logic [255:0] fin [0:1023];
    bit rd_req = 0;
    logic [9:0] rd_a = '0;
    localparam logic [255:0] TOP_ONE = 256'h40000000 << 224;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic bit any_out();
        return |{bus.o_ctx_ready, bus.o_qea_start, bus.o_qea_qbit_num, bus.o_qea_ctx_en,
                 bus.o_qea_ctx_wea, bus.o_qea_ctx_addr, bus.o_qea_ctx_data, bus.o_qea_state_ena,
                 bus.o_qea_state_wea, bus.o_qea_state_addra, bus.o_qea_state_dina, bus.o_out_valid,
                 bus.o_out_data, bus.o_out_last, bus.o_busy, bus.o_done, bus.o_err, bus.o_exec_cycles};
    endfunction

    // One clock: state RAM answers last cycle's read, junk otherwise, then outputs are sampled.
    task automatic tick();
        @(posedge clk);
        #1;
        bus.i_qea_state_dout = rd_req ? fin[rd_a] : rnd256();
        rd_req = bus.o_qea_state_ena && !bus.o_qea_state_wea;
        rd_a = bus.o_qea_state_addra[9:0];
    endtask

    task automatic run_job(input int q, input int n, input bit gap, input int stall, input int d,
                           input bit abort, input bit busy_cmd);
        int dep = 1 << (q - 2);
        logic [79:0] exp_ctx[$];
        logic [63:0] w;
        logic [255:0] prev_d = '0;
        int k = 0, ctx_seen = 0, wr = 0, starts = 0, since = -1, outs = 0, hold = 0, cyc = 0;
        bit done = 0, prev_v = 0, fired = 0, pulsed = 0;
        tick();
        bus.i_qbit_num = 6'(q);
        bus.i_ins_num = 16'(n);
        bus.i_cmd_start = 1'b1;
        while (!done && cyc < 20000) begin
            tick();
            cyc++;
            bus.i_cmd_start = 1'b0;
            bus.i_qea_complete = 1'b0;
            if (busy_cmd && !pulsed && bus.o_ctx_ready) begin
                bus.i_cmd_start = 1'b1;
                bus.i_ins_num = 16'(n + 5);
                bus.i_qbit_num = 6'($urandom_range(2, 8));
                pulsed = 1;
            end
            if (bus.o_qea_ctx_en) begin
                chk("ctx_wea", 256'(bus.o_qea_ctx_wea), 256'(1));
                if (exp_ctx.size() == 0)
                    chk("ctx_extra", 256'(1), 256'(0));
                else
                    chk("ctx_word", 256'({bus.o_qea_ctx_addr, bus.o_qea_ctx_data}), 256'(exp_ctx.pop_front()));
                ctx_seen++;
            end
            w = {$urandom, $urandom};
            bus.i_ctx_word = w;
            bus.i_ctx_valid = gap ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.i_ctx_valid && bus.o_ctx_ready) begin
                exp_ctx.push_back({16'(k), w});
                k++;
            end
            if (bus.o_qea_state_ena && bus.o_qea_state_wea) begin
                chk("init_addr", 256'(bus.o_qea_state_addra), 256'(wr));
                chk("init_data", bus.o_qea_state_dina, wr == 0 ? TOP_ONE : 256'(0));
                wr++;
            end
            if (bus.o_qea_start) begin
                starts++;
                since = 0;
                chk("busy_at_start", 256'(bus.o_busy), 256'(1));
            end else if (since >= 0 && !fired) begin
                since++;
                if (abort && since == d / 2) begin
                    #2 rst = 1'b1;
                    #1 chk("rst_outputs_zero", 256'(any_out()), 256'(0));
                    @(negedge clk);
                    rst = 1'b0;
                    bus.i_ctx_valid = 1'b0;
                    bus.i_out_ready = 1'b0;
                    rd_req = 0;
                    return;
                end
                if (since == d) begin
                    for (int i = 0; i < dep; i++) fin[i] = rnd256();
                    bus.i_qea_complete = 1'b1;
                    fired = 1;
                end
            end
            if (prev_v) begin
                chk("out_valid_held", 256'(bus.o_out_valid), 256'(1));
                chk("out_stable", bus.o_out_data, prev_d);
            end
            prev_v = 0;
            if (bus.o_out_valid) begin
                bus.i_out_ready = hold >= stall;
                hold = bus.i_out_ready ? 0 : hold + 1;
                if (bus.i_out_ready) begin
                    chk("out_data", bus.o_out_data, fin[outs]);
                    chk("out_last", 256'(bus.o_out_last), 256'(outs == dep - 1));
                    outs++;
                end else begin
                    prev_v = 1;
                    prev_d = bus.o_out_data;
                end
            end else
                bus.i_out_ready = 1'($urandom_range(0, 1));
            if (bus.o_done) done = 1;
        end
        bus.i_ctx_valid = 1'b0;
        bus.i_out_ready = 1'b0;
        if (!done) chk("timeout", 256'(0), 256'(1));
        chk("ctx_count", 256'(ctx_seen), 256'(n));
        chk("init_count", 256'(wr), 256'(dep));
        chk("start_count", 256'(starts), 256'(1));
        chk("out_count", 256'(outs), 256'(dep));
        // Count runs on every RUN cycle before the one where complete is seen.
        chk("exec_cycles", 256'(bus.o_exec_cycles), 256'(d - 1));
        chk("err_clear", 256'(bus.o_err), 256'(0));
        chk("qbit_out", 256'(bus.o_qea_qbit_num), 256'(q));
    endtask

    task automatic run_bad(input int q, input int n);
        int dones = 0;
        bit act = 0;
        tick();
        bus.i_qbit_num = 6'(q);
        bus.i_ins_num = 16'(n);
        bus.i_cmd_start = 1'b1;
        bus.i_ctx_valid = 1'b1;
        repeat (6) begin
            tick();
            bus.i_cmd_start = 1'b0;
            dones += int'(bus.o_done);
            act |= bus.o_busy | bus.o_ctx_ready | bus.o_qea_ctx_en | bus.o_qea_state_ena | bus.o_qea_start;
        end
        bus.i_ctx_valid = 1'b0;
        chk("bad_done_pulses", 256'(dones), 256'(1));
        chk("bad_err", 256'(bus.o_err), 256'(1));
        chk("bad_quiet", 256'(act), 256'(0));
    endtask

    initial begin
        rst = 1'b1;
        bus.i_cmd_start = 1'b0;
        bus.i_qbit_num = '0;
        bus.i_ins_num = '0;
        bus.i_ctx_valid = 1'b0;
        bus.i_ctx_word = '0;
        bus.i_qea_complete = 1'b0;
        bus.i_qea_state_dout = '0;
        bus.i_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("reset_outputs_zero", 256'(any_out()), 256'(0));
        @(negedge clk);
        rst = 1'b0;
        run_job(4, 79, 0, 0, 500, 0, 0);
        run_job(3, 20, 1, 0, 30, 0, 0);
        run_job(4, 8, 0, 10, 20, 0, 0);
        run_bad(5, 0);
        run_job(2, 3, 0, 0, 10, 0, 0);
        run_bad(1, 6);
        run_bad(19, 4);
        run_job(2, 1, 1, 1, 7, 0, 0);
        run_job(4, 10, 0, 0, 40, 1, 0);
        run_job(3, 6, 1, 2, 15, 0, 0);
        run_job(4, 30, 1, 0, 20, 0, 1);
        repeat (4)
            run_job($urandom_range(2, 7), $urandom_range(1, 40), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), $urandom_range(2, 60), 0, 1'($urandom_range(0, 1)));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
